hazard_forward_unit: RTL and testbench

Parametrised hazard and forwarding controller for the RISC-V pipeline; sits beside the EX stage. Generates per-operand bypass selects for any number of source operands, detects load-use hazards in ID and holds IF/ID for a configurable data-memory latency, and issues flushes on taken branches. Optional performance counters track stall cycles and flushes.

---
 rtl/hazard_pkg.sv | 5 +
 rtl/fwd_sel.sv | 17 +
 rtl/hazard_forward_unit.sv | 110 +++++++++++
 tb/tb_hazard_forward_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared encodings for the hazard/forwarding unit
package hazard_pkg;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_ME = 2'b01, FWD_WB = 2'b10} fwd_sel_e;
  typedef enum logic {IDLE, STALL} hz_state_e;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: bypass select for one EX source operand
// Ports: rs (EX source index), rd_me/ru_write_me and rd_wb/ru_write_wb (producer stages), sel (RF/ME/WB select)
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rd_me,
  input  logic                  ru_write_me,
  input  logic [REG_ADDR_W-1:0] rd_wb,
  input  logic                  ru_write_wb,
  output fwd_sel_e              sel
);
  assign sel = (ru_write_me && |rd_me && rd_me == rs) ? FWD_ME :
               (ru_write_wb && |rd_wb && rd_wb == rs) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX bypass selects, load-use stall FSM and branch flush control
// Ports: ID sources (rs_id, rs_used_id), EX/ME/WB producer info, branch_taken_ex;
//   outputs rs_sel, stall_if, stall_id, flush_id, flush_ex, stall_cnt, flush_cnt.
// Macro HAZARD_PERF_EN builds the saturating stall/flush counters; otherwise both read 0.
// All outputs are held at 0 while rst_n is low.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]   rs_id,
  input  logic [NUM_SRC-1:0]                   rs_used_id,
  input  logic [NUM_SRC-1:0][REG_ADDR_W-1:0]   rs_ex,
  input  logic [REG_ADDR_W-1:0]                rd_ex,
  input  logic                                 ru_write_ex,
  input  logic                                 mem_read_ex,
  input  logic [REG_ADDR_W-1:0]                rd_me,
  input  logic                                 ru_write_me,
  input  logic [REG_ADDR_W-1:0]                rd_wb,
  input  logic                                 ru_write_wb,
  input  logic                                 branch_taken_ex,
  output logic [NUM_SRC-1:0][1:0]              rs_sel,
  output logic                                 stall_if,
  output logic                                 stall_id,
  output logic                                 flush_id,
  output logic                                 flush_ex,
  output logic [CNT_W-1:0]                     stall_cnt,
  output logic [CNT_W-1:0]                     flush_cnt
);
  localparam int CW = $clog2(LOAD_LAT + 1);
  hz_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_SRC-1:0] hit;
  logic hazard;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_sel_e s;
    fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
      .rs(rs_ex[g]), .rd_me(rd_me), .ru_write_me(ru_write_me),
      .rd_wb(rd_wb), .ru_write_wb(ru_write_wb), .sel(s)
    );
    assign rs_sel[g] = rst_n ? s : FWD_RF;
    assign hit[g] = rs_used_id[g] && rs_id[g] == rd_ex;
  end
  assign hazard = mem_read_ex && ru_write_ex && |rd_ex && |hit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  // A taken branch always wins: it kills both the younger instruction and any pending stall.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    if (rst_n)
      case (state)
        IDLE:
          if (branch_taken_ex) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
          end else if (hazard) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
            if (LOAD_LAT > 1) begin
              state_n = STALL;
              cnt_n   = CW'(LOAD_LAT - 1);
            end
          end
        STALL:
          if (branch_taken_ex) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
            state_n  = IDLE;
            cnt_n    = '0;
          end else begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
            cnt_n    = cnt - CW'(1);
            state_n  = cnt == CW'(1) ? IDLE : STALL;
          end
        default: state_n = IDLE;
      endcase
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_if && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_id && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed vector table plus stall/abort/reset sequences
module tb_hazard_forward_unit;
  localparam int CNT_W = 3;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {
    logic [4:0] rs_ex0, rs_ex1, rs_id0, rs_id1;
    logic [1:0] used;
    logic [4:0] rd_ex;
    logic       wex, mr;
    logic [4:0] rd_me;
    logic       wme;
    logic [4:0] rd_wb;
    logic       wwb, br;
    logic [1:0] s0, s1;
    logic [3:0] ctl;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [1:0][4:0] rs_id, rs_ex;
  logic [1:0] rs_used_id;
  logic [4:0] rd_ex, rd_me, rd_wb;
  logic ru_write_ex, mem_read_ex, ru_write_me, ru_write_wb, branch_taken_ex;
  logic [1:0][1:0] rs_sel;
  logic stall_if, stall_id, flush_id, flush_ex;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  int checks = 0, failures = 0;
  vec_t tbl [16];
  always #5 clk = ~clk;
  hazard_forward_unit #(.REG_ADDR_W(5), .NUM_SRC(2), .LOAD_LAT(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rs_used_id(rs_used_id), .rs_ex(rs_ex),
    .rd_ex(rd_ex), .ru_write_ex(ru_write_ex), .mem_read_ex(mem_read_ex),
    .rd_me(rd_me), .ru_write_me(ru_write_me), .rd_wb(rd_wb), .ru_write_wb(ru_write_wb),
    .branch_taken_ex(branch_taken_ex), .rs_sel(rs_sel), .stall_if(stall_if),
    .stall_id(stall_id), .flush_id(flush_id), .flush_ex(flush_ex),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic chk_ctl(input string name, input logic [3:0] exp);
    chk(name, {28'd0, stall_if, stall_id, flush_id, flush_ex}, {28'd0, exp});
  endtask
  task automatic drive(input vec_t v);
    rs_ex = {v.rs_ex1, v.rs_ex0};
    rs_id = {v.rs_id1, v.rs_id0};
    rs_used_id = v.used;
    rd_ex = v.rd_ex;
    ru_write_ex = v.wex;
    mem_read_ex = v.mr;
    rd_me = v.rd_me;
    ru_write_me = v.wme;
    rd_wb = v.rd_wb;
    ru_write_wb = v.wwb;
    branch_taken_ex = v.br;
  endtask
  task automatic load_use(input logic [1:0] used);
    drive(tbl[0]);
    mem_read_ex = 1'b1;
    ru_write_ex = 1'b1;
    rd_ex = 5'd7;
    rs_id = {5'd7, 5'd0};
    rs_used_id = used;
  endtask
  initial begin
    //         rs_ex0 ex1 id0 id1 used  rd_ex wex mr rd_me wme rd_wb wwb br  s0 s1 ctl
    tbl[0]  = '{0,  0,  0, 0, 2'b00, 0, 0, 0, 0,  0, 0,  0, 0, 0, 0, 4'b0000};
    tbl[1]  = '{5,  5,  0, 0, 2'b00, 0, 0, 0, 5,  1, 5,  1, 0, 1, 1, 4'b0000};
    tbl[2]  = '{0,  3,  0, 0, 2'b00, 0, 0, 0, 0,  1, 3,  1, 0, 0, 2, 4'b0000};
    tbl[3]  = '{9,  9,  0, 0, 2'b00, 0, 0, 0, 1,  1, 9,  1, 0, 2, 2, 4'b0000};
    tbl[4]  = '{4,  6,  0, 0, 2'b00, 0, 0, 0, 4,  0, 4,  1, 0, 2, 0, 4'b0000};
    tbl[5]  = '{0, 12,  0, 0, 2'b00, 0, 0, 0, 12, 1, 0,  1, 0, 0, 1, 4'b0000};
    tbl[6]  = '{8,  8,  0, 0, 2'b00, 0, 0, 0, 0,  0, 8,  0, 0, 0, 0, 4'b0000};
    tbl[7]  = '{0,  0,  7, 0, 2'b01, 7, 1, 1, 0,  0, 0,  0, 0, 0, 0, 4'b1101};
    tbl[8]  = '{0,  0,  7, 7, 2'b10, 7, 1, 1, 0,  0, 0,  0, 0, 0, 0, 4'b1101};
    tbl[9]  = '{0,  0,  0, 7, 2'b01, 7, 1, 1, 0,  0, 0,  0, 0, 0, 0, 4'b0000};
    tbl[10] = '{0,  0,  0, 0, 2'b11, 0, 1, 1, 0,  0, 0,  0, 0, 0, 0, 4'b0000};
    tbl[11] = '{0,  0,  7, 0, 2'b01, 7, 1, 0, 0,  0, 0,  0, 0, 0, 0, 4'b0000};
    tbl[12] = '{0,  0,  7, 0, 2'b01, 7, 0, 1, 0,  0, 0,  0, 0, 0, 0, 4'b0000};
    tbl[13] = '{0,  0,  0, 0, 2'b00, 0, 0, 0, 0,  0, 0,  0, 1, 0, 0, 4'b0011};
    tbl[14] = '{0,  0,  7, 0, 2'b01, 7, 1, 1, 0,  0, 0,  0, 1, 0, 0, 4'b0011};
    tbl[15] = '{3, 10,  0, 7, 2'b10, 7, 1, 1, 3,  1, 10, 1, 0, 1, 2, 4'b1101};
    drive(tbl[1]);
    branch_taken_ex = 1'b1;
    #12;
    chk("reset_rs_sel", {28'd0, rs_sel}, 32'd0);
    chk_ctl("reset_ctl", 4'b0000);
    chk("reset_cnts", {26'd0, stall_cnt, flush_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(tbl[0]);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d_sel0", i), {30'd0, rs_sel[0]}, {30'd0, tbl[i].s0});
      chk($sformatf("vec%0d_sel1", i), {30'd0, rs_sel[1]}, {30'd0, tbl[i].s1});
      chk_ctl($sformatf("vec%0d_ctl", i), tbl[i].ctl);
      @(negedge clk);
      drive(tbl[0]);
      repeat (3) @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("cnts_cleared", {26'd0, stall_cnt, flush_cnt}, 32'd0);
    @(negedge clk);
    load_use(2'b10);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk_ctl($sformatf("stall_cyc%0d", c), 4'b1101);
      @(negedge clk);
    end
    drive(tbl[0]);
    #1;
    chk_ctl("stall_end", 4'b0000);
    chk("stall_cnt_3", {29'd0, stall_cnt}, PERF ? 32'd3 : 32'd0);
    @(negedge clk);
    load_use(2'b01);
    #1;
    chk_ctl("unused_src", 4'b0000);
    @(negedge clk);
    #1;
    chk_ctl("unused_src_next", 4'b0000);
    @(negedge clk);
    load_use(2'b10);
    #1;
    chk_ctl("abort_detect", 4'b1101);
    @(negedge clk);
    branch_taken_ex = 1'b1;
    #1;
    chk_ctl("abort_branch", 4'b0011);
    @(negedge clk);
    drive(tbl[0]);
    #1;
    chk_ctl("abort_idle", 4'b0000);
    chk("abort_stall_cnt", {29'd0, stall_cnt}, PERF ? 32'd4 : 32'd0);
    chk("abort_flush_cnt", {29'd0, flush_cnt}, PERF ? 32'd1 : 32'd0);
    @(negedge clk);
    #1;
    chk_ctl("abort_idle_next", 4'b0000);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      load_use(2'b10);
      repeat (3) @(negedge clk);
      drive(tbl[0]);
    end
    #1;
    chk("stall_cnt_sat", {29'd0, stall_cnt}, PERF ? 32'd7 : 32'd0);
    @(negedge clk);
    load_use(2'b10);
    rs_ex = {5'd0, 5'd5};
    rd_me = 5'd5;
    ru_write_me = 1'b1;
    #1;
    chk_ctl("rst_detect", 4'b1101);
    @(negedge clk);
    #1;
    chk_ctl("rst_in_stall", 4'b1101);
    rst_n = 1'b0;
    #1;
    chk_ctl("rst_mid_ctl", 4'b0000);
    chk("rst_mid_sel", {28'd0, rs_sel}, 32'd0);
    chk("rst_mid_cnts", {26'd0, stall_cnt, flush_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_read_ex = 1'b0;
    #1;
    chk_ctl("post_rst", 4'b0000);
    chk("post_rst_sel0", {30'd0, rs_sel[0]}, 32'd1);
    @(negedge clk);
    #1;
    chk_ctl("post_rst_next", 4'b0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
